// File: rtl/load_constant_pkg.sv
// Datapath constants shared by operand-path stages.
// IMM_W: default immediate/constant width.
package load_constant_pkg;

  localparam int IMM_W = 20;

endpackage

// File: rtl/load_constant.sv
// Load-constant stage: registers C onto R, bit-exact, 1-cycle latency.
// Ports: clk, rst (sync active-high), C (WIDTH in), R (WIDTH out).
module load_constant
  import load_constant_pkg::*;
#(
  parameter int WIDTH = IMM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] R
);

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;

  always_comb begin
    r_d = C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign R = r_q;

endmodule

// File: tb/tb_load_constant.sv
// Self-checking bench for load_constant at WIDTH 20 (default), 8, 32.
// Directed plus random steps checked against a one-cycle-delay model.
module tb_load_constant;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] c20 = '0;
  logic [7:0]  c8  = '0;
  logic [31:0] c32 = '0;
  logic [19:0] r20;
  logic [7:0]  r8;
  logic [31:0] r32;

  int errors = 0;
  int checks = 0;

  logic        have = 1'b0;
  logic [19:0] e20;
  logic [7:0]  e8;
  logic [31:0] e32;

  always #5 clk = ~clk;

  load_constant u_d20 (
    .clk(clk), .rst(rst), .C(c20), .R(r20)
  );

  load_constant #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .C(c8), .R(r8)
  );

  load_constant #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .C(c32), .R(r32)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; R must not move before the edge and must
  // show the sampled C (or 0 under reset) just after it.
  task automatic step(
    input string       tag,
    input logic        r,
    input logic [19:0] a,
    input logic [7:0]  b,
    input logic [31:0] d
  );
    @(negedge clk);
    rst = r;
    c20 = a;
    c8  = b;
    c32 = d;
    #1;
    if (have) begin
      chk({tag, "_hold20"}, {12'b0, r20}, {12'b0, e20});
      chk({tag, "_hold8"},  {24'b0, r8},  {24'b0, e8});
      chk({tag, "_hold32"}, r32, e32);
    end
    @(posedge clk);
    #1;
    e20  = r ? 20'h0 : a;
    e8   = r ? 8'h0  : b;
    e32  = r ? 32'h0 : d;
    have = 1'b1;
    chk({tag, "_r20"}, {12'b0, r20}, {12'b0, e20});
    chk({tag, "_r8"},  {24'b0, r8},  {24'b0, e8});
    chk({tag, "_r32"}, r32, e32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset0", 1'b1, 20'hABCDE, 8'hFF, 32'hFFFF_FFFF);
    step("reset1", 1'b1, 20'hABCDE, 8'hAA, 32'hAAAA_AAAA);

    step("load",  1'b0, 20'h12345, 8'h5A, 32'h1234_5678);
    step("hold",  1'b0, 20'h12345, 8'h5A, 32'h1234_5678);

    step("bnd_ones", 1'b0, 20'hFFFFF, 8'hFF, 32'hFFFF_FFFF);
    step("bnd_zero", 1'b0, 20'h00000, 8'h00, 32'h0000_0000);
    step("bnd_msb",  1'b0, 20'h80001, 8'h81, 32'h8000_0001);
    step("alt_a",    1'b0, 20'hAAAAA, 8'hAA, 32'hAAAA_AAAA);
    step("alt_5",    1'b0, 20'h55555, 8'h55, 32'h5555_5555);

    for (int i = 0; i < 20; i++) begin
      step("walk", 1'b0,
           20'(1) << i,
           8'(1) << (i % 8),
           32'(1) << i);
    end

    step("pri_pre",  1'b0, 20'h12345, 8'h3C, 32'hDEAD_BEEF);
    step("pri_rst",  1'b1, 20'h5A5A5, 8'hC3, 32'hCAFE_F00D);
    step("pri_rel",  1'b0, 20'h5A5A5, 8'hC3, 32'hCAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      step("rand",
           ($urandom_range(7) == 0),
           20'($urandom),
           8'($urandom),
           32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
